// File: rtl/led_adder_accum_if.sv
`default_nettype none
// ============================================================================
// Module   : led_adder_accum_if
// Brief    : Switch/button/LED bundle between the board I/O and led_adder_accum.
// Revision : 1.0 - initial release
// ============================================================================
interface led_adder_accum_if #(
    parameter int W     = 2,
    parameter int LED_W = 3
);
    logic [W-1:0]     v1;
    logic [W-1:0]     v2;
    logic             btn_add;
    logic             btn_clr;
    logic             mode;
    logic [LED_W-1:0] led;
    logic             ovf;

    modport master (
        output v1, v2, btn_add, btn_clr, mode,
        input  led, ovf
    );

    modport slave (
        input  v1, v2, btn_add, btn_clr, mode,
        output led, ovf
    );
endinterface
`default_nettype wire

// File: rtl/led_adder_accum.sv
`default_nettype none
// ============================================================================
// Module   : led_adder_accum
// Brief    : Switch adder / LED driver with live view, debounced accumulator,
//            wrap-or-saturate overflow and blinking overflow indication.
// Revision : 1.0 - initial release
// ============================================================================
module led_adder_accum #(
    parameter int W          = 2,
    parameter int LED_W      = 3,
    parameter int DEB_CYCLES = 16,
    parameter int SAT        = 0,
    parameter int BLINK_DIV  = 8
) (
    input  logic             clk,
    input  logic             rst,
    led_adder_accum_if.slave bus
);

    // Arithmetic width wide enough that acc + sum can never wrap internally
    localparam int c_AW = ((W + 1 > LED_W) ? W + 1 : LED_W) + 1;
    localparam int c_CW = $clog2(DEB_CYCLES);
    localparam int c_BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [c_AW-1:0]  c_LED_MAX    = c_AW'((1 << LED_W) - 1);
    localparam logic [c_CW-1:0]  c_DEB_LAST   = c_CW'(DEB_CYCLES - 1);
    localparam logic [c_BW-1:0]  c_BLINK_LAST = c_BW'(BLINK_DIV - 1);
    localparam logic [LED_W-1:0] c_ONES       = {LED_W{1'b1}};

    localparam logic [1:0] c_ST_LIVE = 2'd0;
    localparam logic [1:0] c_ST_ACC  = 2'd1;
    localparam logic [1:0] c_ST_OVF  = 2'd2;

    logic [W-1:0]     r_v1_m, r_v1_s, r_v2_m, r_v2_s;
    logic             r_mode_m, r_mode_s;
    logic [W:0]       r_sum;
    logic [LED_W-1:0] r_acc;
    logic             r_sticky;
    logic [c_BW-1:0]  r_blink_cnt;
    logic             r_blink_ph;
    logic [1:0]       r_state;
    logic [LED_W-1:0] r_led;
    logic             r_ovf;

    logic [1:0]       w_btn_raw;
    logic [1:0]       w_pulse;
    logic [c_AW-1:0]  w_sum_ext;
    logic [c_AW-1:0]  w_acc_sum;
    logic             w_live_ovf;
    logic             w_acc_ovf;
    logic [LED_W-1:0] w_live_led;
    logic [LED_W-1:0] w_acc_fit;
    logic             w_clr;
    logic             w_add_ok;
    logic             w_sticky_nxt;
    logic [1:0]       w_state_nxt;
    logic [LED_W-1:0] w_led_nxt;
    logic             w_ovf_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1_m   <= '0;
            r_v1_s   <= '0;
            r_v2_m   <= '0;
            r_v2_s   <= '0;
            r_mode_m <= 1'b0;
            r_mode_s <= 1'b0;
            r_sum    <= '0;
        end else begin
            r_v1_m   <= bus.v1;
            r_v1_s   <= r_v1_m;
            r_v2_m   <= bus.v2;
            r_v2_s   <= r_v2_m;
            r_mode_m <= bus.mode;
            r_mode_s <= r_mode_m;
            r_sum    <= {1'b0, r_v1_s} + {1'b0, r_v2_s};
        end
    end

    assign w_btn_raw = {bus.btn_clr, bus.btn_add};

    // Index 0 = add button, index 1 = clear button
    for (genvar gi = 0; gi < 2; gi++) begin : g_deb
        logic            r_meta;
        logic            r_sync;
        logic            r_stable;
        logic            r_stable_d;
        logic            r_pulse;
        logic [c_CW-1:0] r_cnt;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_meta     <= 1'b0;
                r_sync     <= 1'b0;
                r_stable   <= 1'b0;
                r_stable_d <= 1'b0;
                r_pulse    <= 1'b0;
                r_cnt      <= '0;
            end else begin
                r_meta     <= w_btn_raw[gi];
                r_sync     <= r_meta;
                r_stable_d <= r_stable;
                r_pulse    <= r_stable & ~r_stable_d;
                if (r_sync != r_stable) begin
                    if (r_cnt == c_DEB_LAST) begin
                        r_stable <= r_sync;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end else begin
                    r_cnt <= '0;
                end
            end
        end

        assign w_pulse[gi] = r_pulse;
    end

    assign w_sum_ext  = c_AW'(r_sum);
    assign w_acc_sum  = c_AW'(r_acc) + w_sum_ext;
    assign w_live_ovf = (w_sum_ext > c_LED_MAX);
    assign w_acc_ovf  = (w_acc_sum > c_LED_MAX);
    assign w_live_led = (w_live_ovf && (SAT != 0)) ? c_ONES : w_sum_ext[LED_W-1:0];
    assign w_acc_fit  = (w_acc_ovf && (SAT != 0)) ? c_ONES : w_acc_sum[LED_W-1:0];

    // Clear has priority; adds only count while the accumulator is on display
    assign w_clr        = w_pulse[1];
    assign w_add_ok     = w_pulse[0] & ~w_clr & (r_state != c_ST_LIVE);
    assign w_sticky_nxt = w_clr ? 1'b0 : ((w_add_ok && w_acc_ovf) ? 1'b1 : r_sticky);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= '0;
            r_sticky <= 1'b0;
        end else begin
            if (w_clr) begin
                r_acc <= '0;
            end else if (w_add_ok) begin
                r_acc <= w_acc_fit;
            end
            r_sticky <= w_sticky_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_LIVE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_LIVE: begin
                if (r_mode_s) begin
                    w_state_nxt = w_sticky_nxt ? c_ST_OVF : c_ST_ACC;
                end
            end
            c_ST_ACC: begin
                if (!r_mode_s) begin
                    w_state_nxt = c_ST_LIVE;
                end else if (w_sticky_nxt) begin
                    w_state_nxt = c_ST_OVF;
                end
            end
            c_ST_OVF: begin
                if (!r_mode_s) begin
                    w_state_nxt = c_ST_LIVE;
                end else if (!w_sticky_nxt) begin
                    w_state_nxt = c_ST_ACC;
                end
            end
            default: w_state_nxt = c_ST_LIVE;
        endcase
    end

    // Blink timer only runs while staying in ACC_OVF, so every entry starts on "acc shown"
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b0;
        end else if ((r_state != c_ST_OVF) || (w_state_nxt != c_ST_OVF)) begin
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b0;
        end else if (r_blink_cnt == c_BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_blink_ph  <= ~r_blink_ph;
        end else begin
            r_blink_cnt <= r_blink_cnt + c_BW'(1);
        end
    end

    always_comb begin
        w_led_nxt = '0;
        w_ovf_nxt = 1'b0;
        case (r_state)
            c_ST_LIVE: begin
                w_led_nxt = w_live_led;
                w_ovf_nxt = w_live_ovf;
            end
            c_ST_ACC: begin
                w_led_nxt = r_acc;
            end
            c_ST_OVF: begin
                w_led_nxt = r_blink_ph ? '0 : r_acc;
                w_ovf_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_led <= w_led_nxt;
            r_ovf <= w_ovf_nxt;
        end
    end

    assign bus.led = r_led;
    assign bus.ovf = r_ovf;

endmodule
`default_nettype wire
